// File: rtl/legv8_pkg.sv
// Shared LEGv8 multicycle-control definitions: state encodings, opcode
// constants, CBZ/B match masks, ALU op codes and the control-word payload.
package legv8_pkg;

  localparam int unsigned OPC_BITS = 11;
  localparam int unsigned STATE_W  = 4;
  localparam int unsigned ALU_OP_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EX_R      = 4'd2,
    S_EX_ADDR   = 4'd3,
    S_MEM_RD    = 4'd4,
    S_MEM_WR    = 4'd5,
    S_WB_R      = 4'd6,
    S_WB_MEM    = 4'd7,
    S_BRANCH_CB = 4'd8,
    S_BRANCH_B  = 4'd9
  } state_e;

  localparam logic [ALU_OP_W-1:0] ALU_ADD   = 2'b00;
  localparam logic [ALU_OP_W-1:0] ALU_PASSB = 2'b01;
  localparam logic [ALU_OP_W-1:0] ALU_RTYPE = 2'b10;

  localparam logic [OPC_BITS-1:0] OPC_ADD  = 11'b10001011000;
  localparam logic [OPC_BITS-1:0] OPC_SUB  = 11'b11001011000;
  localparam logic [OPC_BITS-1:0] OPC_AND  = 11'b10001010000;
  localparam logic [OPC_BITS-1:0] OPC_ORR  = 11'b10101010000;
  localparam logic [OPC_BITS-1:0] OPC_LDUR = 11'b11111000010;
  localparam logic [OPC_BITS-1:0] OPC_STUR = 11'b11111000000;

  // CBZ keeps its low 3 opcode bits as part of the immediate; B keeps 5.
  localparam logic [OPC_BITS-1:0] CBZ_MASK  = 11'b11111111000;
  localparam logic [OPC_BITS-1:0] CBZ_MATCH = 11'b10110100000;
  localparam logic [OPC_BITS-1:0] B_MASK    = 11'b11111100000;
  localparam logic [OPC_BITS-1:0] B_MATCH   = 11'b00010100000;

  typedef enum logic [2:0] {
    CLS_RTYPE   = 3'd0,
    CLS_LDUR    = 3'd1,
    CLS_STUR    = 3'd2,
    CLS_CBZ     = 3'd3,
    CLS_B       = 3'd4,
    CLS_ILLEGAL = 3'd5
  } opc_class_e;

  typedef struct packed {
    logic                ir_write;
    logic                pc_write;
    logic                pc_write_cond;
    logic                mem_read;
    logic                mem_write;
    logic                reg_write;
    logic                reg2loc;
    logic                alu_src;
    logic                mem_to_reg;
    logic                pc_src;
    logic [ALU_OP_W-1:0] alu_op;
    logic                illegal;
  } ctrl_t;

  // Map an 11-bit opcode field onto the instruction class the FSM cares about.
  function automatic opc_class_e classify(input logic [OPC_BITS-1:0] opc);
    if (opc == OPC_ADD || opc == OPC_SUB || opc == OPC_AND || opc == OPC_ORR)
      return CLS_RTYPE;
    if (opc == OPC_LDUR) return CLS_LDUR;
    if (opc == OPC_STUR) return CLS_STUR;
    if ((opc & CBZ_MASK) == CBZ_MATCH) return CLS_CBZ;
    if ((opc & B_MASK) == B_MATCH) return CLS_B;
    return CLS_ILLEGAL;
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational control decode for the multicycle LEGv8 controller.
// Ports:
//   state     - current FSM state
//   opc_class - class of the held opcode (only used in DECODE / EX_ADDR)
//   mem_ready - memory handshake, qualifies the FETCH write strobes
//   active    - low while reset is asserted; suppresses FETCH strobes
//   ctrl      - full control word for the datapath
module mc_decode
  import legv8_pkg::*;
(
  input  state_e     state,
  input  opc_class_e opc_class,
  input  logic       mem_ready,
  input  logic       active,
  output ctrl_t      ctrl
);

  logic uses_rt;

  // STUR and CBZ read Rt through the second register port.
  assign uses_rt = (opc_class == CLS_STUR) || (opc_class == CLS_CBZ);

  // Per-state control word; everything not named stays 0.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read = 1'b1;
        // PC+4 and IR load happen only on the completing fetch cycle, and
        // never while reset holds the machine in FETCH.
        if (mem_ready && active) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
        end
        ctrl.alu_op = ALU_ADD;
      end
      S_DECODE: begin
        ctrl.reg2loc = uses_rt;
        ctrl.illegal = (opc_class == CLS_ILLEGAL);
      end
      S_EX_R: begin
        ctrl.alu_op = ALU_RTYPE;
      end
      S_EX_ADDR: begin
        ctrl.alu_op  = ALU_ADD;
        ctrl.alu_src = 1'b1;
        ctrl.reg2loc = uses_rt;
      end
      S_MEM_RD: ctrl.mem_read  = 1'b1;
      S_MEM_WR: ctrl.mem_write = 1'b1;
      S_WB_R: begin
        ctrl.reg_write = 1'b1;
      end
      S_WB_MEM: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_BRANCH_CB: begin
        ctrl.alu_op        = ALU_PASSB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_src        = 1'b1;
      end
      S_BRANCH_B: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle LEGv8 main controller (Moore FSM).
// Ports:
//   clk, reset_n   - rising-edge clock, asynchronous active-low reset
//   opcode         - instruction register bits 31:21, stable after FETCH
//   mem_ready      - memory access completes this cycle
//   zero           - ALU zero flag (branch gating is done outside)
//   ir_write .. pc_src, alu_op, illegal - datapath control strobes
//   state          - current state encoding for debug
module multicycle_control
  import legv8_pkg::*;
#(
  parameter int unsigned OPC_W = 11
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [OPC_W-1:0]    opcode,
  input  logic                mem_ready,
  input  logic                zero,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_write,
  output logic                reg2loc,
  output logic                alu_src,
  output logic                mem_to_reg,
  output logic                pc_src,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                illegal,
  output logic [STATE_W-1:0]  state
);

  state_e     state_q;
  state_e     state_d;
  opc_class_e opc_class;
  ctrl_t      ctrl;
  logic       unused_inputs;

  // The opcode field occupies the top OPC_BITS of the supplied vector.
  assign opc_class = classify(opcode[OPC_W-1 -: OPC_BITS]);

  // zero is consumed by the external pc_write_cond gate.
  assign unused_inputs = ^{zero, opcode};

  // State register; reset drops straight to FETCH without a clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  // Next-state logic; opcode is only consulted in DECODE and EX_ADDR.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opc_class)
          CLS_RTYPE:            state_d = S_EX_R;
          CLS_LDUR, CLS_STUR:   state_d = S_EX_ADDR;
          CLS_CBZ:              state_d = S_BRANCH_CB;
          CLS_B:                state_d = S_BRANCH_B;
          default:              state_d = S_FETCH;
        endcase
      end
      S_EX_R:      state_d = S_WB_R;
      S_EX_ADDR:   state_d = (opc_class == CLS_LDUR) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:    if (mem_ready) state_d = S_WB_MEM;
      S_MEM_WR:    if (mem_ready) state_d = S_FETCH;
      S_WB_R:      state_d = S_FETCH;
      S_WB_MEM:    state_d = S_FETCH;
      S_BRANCH_CB: state_d = S_FETCH;
      S_BRANCH_B:  state_d = S_FETCH;
      default:     state_d = S_FETCH;
    endcase
  end

  // Output decode from the current state.
  mc_decode u_decode (
    .state     (state_q),
    .opc_class (opc_class),
    .mem_ready (mem_ready),
    .active    (reset_n),
    .ctrl      (ctrl)
  );

  assign ir_write      = ctrl.ir_write;
  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign reg_write     = ctrl.reg_write;
  assign reg2loc       = ctrl.reg2loc;
  assign alu_src       = ctrl.alu_src;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign pc_src        = ctrl.pc_src;
  assign alu_op        = ctrl.alu_op;
  assign illegal       = ctrl.illegal;
  assign state         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control. Each instruction is
// expanded into an expected per-cycle trace from the instruction-level rules,
// and instruction totals are checked against plain cycle/strobe arithmetic.
module tb_multicycle_control;
  import legv8_pkg::*;

  localparam int C_R = 0, C_LD = 1, C_ST = 2, C_CBZ = 3, C_B = 4, C_ILL = 5;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] opcode;
  logic        mem_ready;
  logic        zero;
  logic        ir_write, pc_write, pc_write_cond, mem_read, mem_write;
  logic        reg_write, reg2loc, alu_src, mem_to_reg, pc_src, illegal;
  logic [1:0]  alu_op;
  logic [3:0]  state;
  logic [12:0] obs;

  int n_checks = 0;
  int n_errors = 0;
  int base_cycles [6] = '{4, 5, 4, 3, 3, 2};

  typedef struct {
    logic [3:0]  st;
    logic [12:0] out;
    logic        rdy;
  } step_t;
  step_t plan [$];

  always #5 clk = ~clk;

  multicycle_control #(.OPC_W(11)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
    .zero(zero), .ir_write(ir_write), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .reg2loc(reg2loc), .alu_src(alu_src),
    .mem_to_reg(mem_to_reg), .pc_src(pc_src), .alu_op(alu_op),
    .illegal(illegal), .state(state)
  );

  assign obs = {ir_write, pc_write, pc_write_cond, mem_read, mem_write, reg_write,
                reg2loc, alu_src, mem_to_reg, pc_src, alu_op, illegal};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Control word in obs order.
  function automatic logic [12:0] mk(input logic ir, input logic pw, input logic pwc,
                                     input logic mr, input logic mw, input logic rw,
                                     input logic r2l, input logic as_, input logic m2r,
                                     input logic ps, input logic [1:0] aop, input logic ill);
    return {ir, pw, pwc, mr, mw, rw, r2l, as_, m2r, ps, aop, ill};
  endfunction

  function automatic bit is_legal(input logic [10:0] o);
    return (o == 11'b10001011000) || (o == 11'b11001011000) || (o == 11'b10001010000) ||
           (o == 11'b10101010000) || (o == 11'b11111000010) || (o == 11'b11111000000) ||
           (o ==? 11'b10110100???) || (o ==? 11'b000101?????);
  endfunction

  function automatic logic [10:0] pick_opc(input int cls);
    logic [10:0] rt [4] = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000};
    logic [10:0] o;
    case (cls)
      C_R:   o = rt[$urandom_range(3)];
      C_LD:  o = 11'b11111000010;
      C_ST:  o = 11'b11111000000;
      C_CBZ: o = {8'b10110100, 3'($urandom)};
      C_B:   o = {6'b000101, 5'($urandom)};
      default: begin
        o = 11'b11111111111;
        for (int k = 0; k < 50; k++) begin
          o = 11'($urandom);
          if (!is_legal(o)) break;
          o = 11'b11111111111;
        end
      end
    endcase
    return o;
  endfunction

  task automatic push(input logic [3:0] st, input logic [12:0] out, input logic rdy);
    step_t s;
    s.st = st; s.out = out; s.rdy = rdy;
    plan.push_back(s);
  endtask

  // Expected cycle-by-cycle trace of one instruction.
  task automatic build(input int cls, input int fw, input int mw);
    logic r2l;
    r2l = (cls == C_ST) || (cls == C_CBZ);
    plan.delete();
    repeat (fw) push(S_FETCH, mk(0,0,0,1,0,0,0,0,0,0,2'b00,0), 1'b0);
    push(S_FETCH,  mk(1,1,0,1,0,0,0,0,0,0,2'b00,0), 1'b1);
    push(S_DECODE, mk(0,0,0,0,0,0,r2l,0,0,0,2'b00,(cls == C_ILL)), 1'($urandom));
    case (cls)
      C_R: begin
        push(S_EX_R, mk(0,0,0,0,0,0,0,0,0,0,2'b10,0), 1'($urandom));
        push(S_WB_R, mk(0,0,0,0,0,1,0,0,0,0,2'b00,0), 1'($urandom));
      end
      C_LD: begin
        push(S_EX_ADDR, mk(0,0,0,0,0,0,0,1,0,0,2'b00,0), 1'($urandom));
        repeat (mw) push(S_MEM_RD, mk(0,0,0,1,0,0,0,0,0,0,2'b00,0), 1'b0);
        push(S_MEM_RD, mk(0,0,0,1,0,0,0,0,0,0,2'b00,0), 1'b1);
        push(S_WB_MEM, mk(0,0,0,0,0,1,0,0,1,0,2'b00,0), 1'($urandom));
      end
      C_ST: begin
        push(S_EX_ADDR, mk(0,0,0,0,0,0,1,1,0,0,2'b00,0), 1'($urandom));
        repeat (mw) push(S_MEM_WR, mk(0,0,0,0,1,0,0,0,0,0,2'b00,0), 1'b0);
        push(S_MEM_WR, mk(0,0,0,0,1,0,0,0,0,0,2'b00,0), 1'b1);
      end
      C_CBZ: push(S_BRANCH_CB, mk(0,0,1,0,0,0,0,0,0,1,2'b01,0), 1'($urandom));
      C_B:   push(S_BRANCH_B,  mk(0,1,0,0,0,0,0,0,0,1,2'b00,0), 1'($urandom));
      default: ;
    endcase
  endtask

  // Run one instruction; abort_at >= 0 drops reset_n mid-cycle at that step.
  task automatic run_instr(input int cls, input logic [10:0] opc, input int fw,
                           input int mw, input int abort_at);
    int  cyc = 0, rw_n = 0, mw_n = 0, mrm_n = 0, ill_n = 0, pwc_n = 0, pw_n = 0;
    bit  left = 0, aborted = 0;
    int  exp_cyc;
    build(cls, fw, mw);
    foreach (plan[i]) begin
      @(negedge clk);
      mem_ready = plan[i].rdy;
      zero      = 1'($urandom);
      if (plan[i].st == 4'(S_DECODE))     opcode = opc;
      else if (plan[i].st == 4'(S_FETCH)) opcode = 11'($urandom);
      #1;
      check("state", 32'(state), 32'(plan[i].st));
      check("ctrl",  32'(obs),   32'(plan[i].out));
      if (state != 4'(S_FETCH)) left = 1;
      if (!left || state != 4'(S_FETCH)) cyc++;
      rw_n  += int'(reg_write);
      mw_n  += int'(mem_write);
      ill_n += int'(illegal);
      pwc_n += int'(pc_write_cond);
      pw_n  += int'(pc_write);
      if (state != 4'(S_FETCH)) mrm_n += int'(mem_read);
      if (i == abort_at) begin
        #2;
        mem_ready = 1'b1;
        reset_n   = 1'b0;
        #1;
        check("rst_async_state", 32'(state), 32'(S_FETCH));
        check("rst_async_ctrl",  32'(obs),   32'(mk(0,0,0,1,0,0,0,0,0,0,2'b00,0)));
        @(posedge clk);
        #1;
        check("rst_hold_state", 32'(state), 32'(S_FETCH));
        check("rst_hold_ctrl",  32'(obs),   32'(mk(0,0,0,1,0,0,0,0,0,0,2'b00,0)));
        #1 reset_n = 1'b1;
        aborted = 1;
        break;
      end
    end
    if (!aborted) begin
      exp_cyc = base_cycles[cls] + fw + (((cls == C_LD) || (cls == C_ST)) ? mw : 0);
      check("cycles",        32'(cyc),   32'(exp_cyc));
      check("reg_write_cnt", 32'(rw_n),  32'(((cls == C_R) || (cls == C_LD)) ? 1 : 0));
      check("mem_write_cnt", 32'(mw_n),  32'((cls == C_ST) ? 1 + mw : 0));
      check("mem_rd_cnt",    32'(mrm_n), 32'((cls == C_LD) ? 1 + mw : 0));
      check("illegal_cnt",   32'(ill_n), 32'((cls == C_ILL) ? 1 : 0));
      check("pwc_cnt",       32'(pwc_n), 32'((cls == C_CBZ) ? 1 : 0));
      check("pc_write_cnt",  32'(pw_n),  32'((cls == C_B) ? 2 : 1));
    end
  endtask

  initial begin
    int cls, fw, mw, ab;
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    zero      = 1'b0;
    opcode    = 11'h7ff;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'(state), 32'(S_FETCH));
    check("reset_ctrl",  32'(obs),   32'(mk(0,0,0,1,0,0,0,0,0,0,2'b00,0)));
    #1 reset_n = 1'b1;

    // Directed cases
    run_instr(C_R,   11'b10001011000, 0, 0, -1);
    run_instr(C_LD,  11'b11111000010, 0, 2, -1);
    run_instr(C_ST,  11'b11111000000, 0, 0, -1);
    run_instr(C_CBZ, 11'b10110100101, 0, 0, -1);
    run_instr(C_B,   11'b00010111111, 0, 0, -1);
    run_instr(C_ILL, 11'b11111111111, 0, 0, -1);
    run_instr(C_ST,  11'b11111000000, 1, 1, 4);
    run_instr(C_R,   11'b11001011000, 0, 0, 3);
    run_instr(C_LD,  11'b11111000010, 2, 1, -1);

    // Randomized instruction stream with occasional mid-instruction resets
    for (int n = 0; n < 120; n++) begin
      cls = int'($urandom_range(5));
      fw  = int'($urandom_range(2));
      mw  = int'($urandom_range(2));
      ab  = ($urandom_range(15) == 0) ? int'($urandom_range(6)) : -1;
      run_instr(cls, pick_opc(cls), fw, mw, ab);
    end

    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("end_state", 32'(state), 32'(S_FETCH));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter OPC_W, default 11, meaning instruction opcode field width (bits 31:21).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port opcode  input  OPC_W  instruction register bits 31:21.
REQ-005 SHALL have port mem_ready  input  1  memory access complete this cycle.
REQ-006 SHALL have port zero  input  1  ALU zero flag.
REQ-007 SHALL have outputs ir_write, pc_write, pc_write_cond, mem_read, mem_write, reg_write, reg2loc, alu_src, mem_to_reg, pc_src, each output 1 bit, with standard LEGv8 meanings; alu_src 0 = ReadData2, 1 = sign-extended immediate; mem_to_reg 0 = ALU result, 1 = memory data.
REQ-008 SHALL have port alu_op  output  2  00 = add, 01 = pass-B/zero-test, 10 = R-type funct.
REQ-009 SHALL have port illegal  output  1  one-cycle pulse on an unrecognised opcode.
REQ-010 SHALL have port state  output  4  current state encoding, for debug.

Function
REQ-011 SHALL be a Moore FSM: the state register is clocked, and all outputs are decoded from state only, except pc_write_cond gating, which is done externally with zero.
REQ-012 SHALL have the states FETCH, DECODE, EX_R, EX_ADDR, MEM_RD, MEM_WR, WB_R, WB_MEM, BRANCH_CB, BRANCH_B.
REQ-013 SHALL assert mem_read in FETCH; it SHALL stay in FETCH while mem_ready = 0; on mem_ready = 1 it SHALL assert ir_write and pc_write (PC+4, alu_src = 0, pc_src = 0) and go to DECODE.
REQ-014 SHALL go from DECODE, based on opcode, to:
- EX_R for 10001011000 (ADD), 11001011000 (SUB), 10001010000 (AND), 10101010000 (ORR)
- EX_ADDR for 11111000010 (LDUR) or 11111000000 (STUR)
- BRANCH_CB for a 10110100xxx match (CBZ)
- BRANCH_B for a 000101xxxxx match (B)
- otherwise FETCH, with illegal = 1 for that cycle.
REQ-015 SHALL assert reg2loc = 1 in DECODE and EX_ADDR for STUR and CBZ; reg2loc SHALL be 0 otherwise.
REQ-016 SHALL drive alu_op = 10 and alu_src = 0 in EX_R, then go to WB_R.
REQ-017 SHALL assert reg_write = 1 and mem_to_reg = 0 in WB_R, then go to FETCH.
REQ-018 SHALL drive alu_op = 00 and alu_src = 1 in EX_ADDR, then go to MEM_RD for LDUR or MEM_WR for STUR.
REQ-019 SHALL assert mem_read in MEM_RD and mem_write in MEM_WR, holding the state while mem_ready = 0; on mem_ready = 1 it SHALL go to WB_MEM (LDUR) or FETCH (STUR).
REQ-020 SHALL assert reg_write = 1 and mem_to_reg = 1 in WB_MEM, then go to FETCH.
REQ-021 SHALL drive alu_op = 01, alu_src = 0, pc_write_cond = 1 and pc_src = 1 in BRANCH_CB, then go to FETCH.
REQ-022 SHALL drive pc_write = 1 and pc_src = 1 in BRANCH_B, then go to FETCH.
REQ-023 SHALL give the following cycle counts with zero-wait memory: R-type 4, LDUR 5, STUR 4, CBZ 3, B 3; each memory wait cycle SHALL add exactly 1.
REQ-024 SHALL never assert mem_read and mem_write in the same cycle.
REQ-025 SHALL assert reg_write only in WB_R and WB_MEM.
REQ-026 SHALL treat opcode as stable from DECODE until return to FETCH; opcode SHALL be sampled only in DECODE, EX_ADDR and MEM_RD/MEM_WR.
REQ-027 SHALL drive every output not listed for a state to 0 in that state.

Reset
REQ-028 SHALL, while reset_n = 0, force state = FETCH immediately, independent of clk.
REQ-029 SHALL hold all outputs at 0 during reset except mem_read = 1, which is the FETCH decode, and state = FETCH.
REQ-030 SHALL abandon any in-progress instruction when reset is asserted mid-instruction, with no write strobe issued after reset_n falls.

Structure
REQ-031 SHALL take its state encodings, opcode constants, CBZ/B match masks and alu_op codes from the shared package legv8_pkg.
REQ-032 SHALL contain one sub-module, mc_decode, holding the combinational state-to-control-output decode; the next-state logic and state register SHALL stay in the top.

Verification
REQ-033 SHALL be verified with ADD opcode 10001011000 and mem_ready = 1: states FETCH→DECODE→EX_R→WB_R→FETCH, with reg_write high only in cycle 4.
REQ-034 SHALL be verified with LDUR and mem_ready low for 2 cycles in MEM_RD: 7 total cycles, mem_read high for 3 cycles in MEM_RD, and mem_to_reg = 1 in WB_MEM.
REQ-035 SHALL be verified with STUR: mem_write high exactly 1 cycle, reg_write never high, and reg2loc = 1 in DECODE.
REQ-036 SHALL be verified with CBZ opcode 10110100101: pc_write_cond = 1 in cycle 3 and a return to FETCH; and with B opcode 00010111111: pc_write = 1 in cycle 3.
REQ-037 SHALL be verified with opcode 11111111111: illegal pulses 1 cycle in DECODE, no write strobes are asserted, and the next state is FETCH.
REQ-038 SHALL be verified by asserting reset_n = 0 mid-cycle in MEM_WR: state is FETCH and mem_write is 0 asynchronously, before the next clk edge.
